// File: rtl/rfft_pkg.sv
// Shared definitions for the real-FFT input loader.
// Holds frame geometry, the default sample width, the loader state type
// and the 8-bit bit-reversal helper used when RFFT_LOADER_BITREV_EN is defined.
package rfft_pkg;

  localparam int N_POINTS   = 256;
  localparam int N_BANKS    = 4;
  localparam int ADDR_W     = 6;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

  // Reverse the bit order of an 8-bit complex index.
  function automatic logic [7:0] bitrev8(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = k[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rfft_bank_map.sv
// Complex index to bank/address mapping for the loader.
// With RFFT_LOADER_BITREV_EN defined the index is bit-reversed before the
// split: upper two bits select the bank (one-hot), lower six the word address.
module rfft_bank_map
  import rfft_pkg::*;
(
  input  logic [7:0]         k,
  output logic [N_BANKS-1:0] bank_oh,
  output logic [ADDR_W-1:0]  addr
);

  logic [7:0] k_s;

  // Optional reordering, then split the index into one-hot bank and word address.
  always_comb begin
`ifdef RFFT_LOADER_BITREV_EN
    k_s = bitrev8(k);
`else
    k_s = k;
`endif
    addr = k_s[5:0];
    case (k_s[7:6])
      2'd0:    bank_oh = 4'b0001;
      2'd1:    bank_oh = 4'b0010;
      2'd2:    bank_oh = 4'b0100;
      2'd3:    bank_oh = 4'b1000;
      default: bank_oh = 4'b0000;
    endcase
  end

endmodule

// File: rtl/rfft_loader.sv
// Real-FFT input loader: packs 512 real samples into 256 complex words
// (even sample -> real half, odd sample -> imaginary half) spread over four
// banks, then pulses fft_start and waits for a rising edge of fft_done.
// Optional build macro: RFFT_LOADER_BITREV_EN (bit-reversed bank placement).
module rfft_loader
  import rfft_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
)
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [N_BANKS-1:0]   wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [2*WIDTH-1:0]   wr_data,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 frame_err
);

  loader_state_t state_r;
  loader_state_t state_s;

  logic [8:0]         cnt_r;
  logic [WIDTH-1:0]   even_r;
  logic               done_q_r;
  logic               s_ready_r;
  logic [N_BANKS-1:0] wr_en_r;
  logic [ADDR_W-1:0]  wr_addr_r;
  logic [2*WIDTH-1:0] wr_data_r;
  logic               fft_start_r;
  logic               frame_err_r;

  logic               xfer_s;
  logic               final_smp_s;
  logic               early_last_s;
  logic               done_rise_s;
  logic [N_BANKS-1:0] bank_oh_s;
  logic [ADDR_W-1:0]  addr_s;

  assign xfer_s       = s_valid && s_ready_r;
  assign final_smp_s  = (cnt_r == 9'd511);
  assign early_last_s = xfer_s && s_last && !final_smp_s;
  // fft_done is a sticky level, so only its 0->1 edge releases WAIT.
  assign done_rise_s  = fft_done && !done_q_r;

  rfft_bank_map u_bank_map (
    .k       (cnt_r[8:1]),
    .bank_oh (bank_oh_s),
    .addr    (addr_s)
  );

  // Next-state logic: LOAD until the 512th sample, one START cycle, WAIT for done edge.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD: begin
        if (xfer_s && final_smp_s) begin
          state_s = START;
        end else begin
          state_s = LOAD;
        end
      end
      START: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (done_rise_s) begin
          state_s = LOAD;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Sample counter, even-sample holding register, bank write port and status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_r       <= 9'd0;
      even_r      <= {WIDTH{1'b0}};
      done_q_r    <= 1'b0;
      s_ready_r   <= 1'b0;
      wr_en_r     <= {N_BANKS{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {(2*WIDTH){1'b0}};
      fft_start_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      done_q_r    <= fft_done;
      s_ready_r   <= (state_s == LOAD);
      // START has already followed the final write, so the pulse lands one cycle after it.
      fft_start_r <= (state_r == START);
      wr_en_r     <= {N_BANKS{1'b0}};
      if (state_r == WAIT) begin
        cnt_r <= 9'd0;
      end else if (early_last_s) begin
        // Short frame: drop the partial frame including any pending even sample.
        cnt_r       <= 9'd0;
        frame_err_r <= 1'b1;
      end else if (xfer_s) begin
        cnt_r <= cnt_r + 9'd1;
        if (final_smp_s && !s_last) begin
          frame_err_r <= 1'b1;
        end
        if (cnt_r[0] == 1'b0) begin
          even_r <= s_data;
        end else begin
          wr_en_r   <= bank_oh_s;
          wr_addr_r <= addr_s;
          wr_data_r <= {even_r, s_data};
        end
      end
    end
  end

  assign s_ready   = s_ready_r;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign fft_start = fft_start_r;
  assign frame_err = frame_err_r;

endmodule

// File: doc/rfft_loader.md
RFFT_LOADER -- requirements
Module: rfft_loader

Interface
REQ-001 WIDTH, 32, width of one real input sample and of each complex half-word.
REQ-002 Clk  input  1  clock; all logic on rising edge.
REQ-003 Reset_n  input  1  reset, synchronous, active-low.
REQ-004 s_data  input  WIDTH  real input sample, two's complement.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_last  input  1  marks final sample of a frame.
REQ-007 s_ready  output  1  loader accepts a sample this cycle.
REQ-008 wr_en  output  4  one-hot write enable, bit b = bank b.
REQ-009 wr_addr  output  6  bank word address.
REQ-010 wr_data  output  2*WIDTH  complex word: [2W-1:W] real, [W-1:0] imag.
REQ-011 fft_start  output  1  one-cycle pulse: banks hold a complete frame.
REQ-012 fft_done  input  1  FFT completion level from the transform engine.
REQ-013 frame_err  output  1  sticky framing-error flag.

Function
REQ-014 Frame SHALL be 512 real samples, packed into 256 complex points: even sample to real, next odd sample to imag.
REQ-015 Transfer SHALL occur when s_valid && s_ready; 9-bit sample counter cnt SHALL increment per transfer.
REQ-016 Complex index k = cnt[8:1]; bank = k[7:6], wr_addr = k[5:0].
REQ-017 Write SHALL be issued the cycle after the odd-sample transfer; wr_en one-hot for exactly one cycle; wr_en SHALL be 0 otherwise.
REQ-018 FSM states LOAD, START, WAIT; s_ready = 1 only in LOAD.
REQ-019 LOAD->START after transfer with cnt=511; START lasts one cycle, fft_start=1, issued after the final write; START->WAIT.
REQ-020 WAIT->LOAD on 0->1 transition of fft_done (edge-detected, since fft_done is a sticky level); cnt=0 on entry to LOAD.
REQ-021 s_last with cnt<511: frame_err set, cnt cleared, pending even sample discarded, no write for that sample, no fft_start; stay in LOAD.
REQ-022 No s_last at cnt=511: frame treated as complete, fft_start issued, frame_err set.
REQ-023 s_valid outside LOAD SHALL be ignored; no data loss because s_ready=0.
REQ-024 Data SHALL pass unmodified; no scaling or saturation.

Reset
REQ-025 On Reset_n=0: state LOAD, cnt 0, s_ready 0 in the reset cycle then 1, wr_en 0, wr_addr 0, wr_data 0, fft_start 0, frame_err 0, edge register 0.
REQ-026 Reset mid-frame SHALL drop any pending write and partial frame; no fft_start.

Configuration
REQ-027 RFFT_LOADER_BITREV_EN defined: k SHALL be bit-reversed over 8 bits before the bank/address split in REQ-016.
REQ-028 RFFT_LOADER_BITREV_EN undefined: natural order per REQ-016; all other behaviour identical.

Structure
REQ-029 Package rfft_pkg SHALL hold N_POINTS=256, N_BANKS=4, ADDR_W=6, default WIDTH, and the loader state enum.
REQ-030 Sub-module rfft_bank_map SHALL combinationally map k to one-hot bank and address, including the optional bit reversal.

Verification
REQ-031 Ramp samples 0..511, s_valid constant, s_last on 511 -> 256 writes; bank1 addr 0 = {128,129}; fft_start one cycle after last write; frame_err 0.
REQ-032 Same ramp with s_valid toggled randomly -> identical write contents and order; s_ready 0 from START until fft_done rises.
REQ-033 s_last on sample 100 -> frame_err 1, no fft_start; next full ramp -> normal fft_start, frame_err stays 1.
REQ-034 fft_done held high from a prior frame -> no return to LOAD until fft_done falls then rises.
REQ-035 Reset_n low at sample 301 -> no write for complex point 150; cnt restarts; next full frame loads correctly.
REQ-036 RFFT_LOADER_BITREV_EN defined, ramp -> k=1 (samples 2,3) written to bank 2, addr 0.
